// File: rtl/interrupt_gen.sv
// Machine-mode interrupt source: CLINT-style timer, msip bit,
// synchronised external line and a one-shot request FSM.
module interrupt_gen #(
  parameter logic [15:0] TICK_DIV = 16'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ext_irq_in,
  input  logic        csr_meie,
  input  logic        csr_mtie,
  input  logic        csr_msie,
  input  logic        csr_mstatus_mie,
  input  logic        cmd_mret_ex,
  input  logic        stall,
  input  logic        io_we,
  input  logic [2:0]  io_adr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        g_interrupt,
  output logic [1:0]  g_interrupt_priv,
  output logic [3:0]  g_interrupt_code
);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    WAIT_MRET
  } state_t;

  localparam logic [15:0] DIV =
    (TICK_DIV == 16'd0) ? 16'd1 : TICK_DIV;

  state_t      state;
  logic [15:0] presc;
  logic        tick;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [63:0] mtime_inc;
  logic [63:0] mtime_nxt;
  logic        msip;
  logic        sync1;
  logic        meip;
  logic        mtip;
  logic        take;
  logic        hit_mei;
  logic        hit_msi;
  logic [3:0]  code_nxt;
  logic [31:0] mip;

  assign g_interrupt_priv = 2'b11;

  assign tick = (presc == DIV - 16'd1);

  // Prescaler: one mtime tick per DIV clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= 16'd0;
    end else if (tick) begin
      presc <= 16'd0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  assign mtime_inc = mtime + {63'd0, tick};

  // A half written by software replaces its incremented value
  always_comb begin
    mtime_nxt = mtime_inc;
    if (io_we && io_adr == 3'd0) begin
      mtime_nxt[31:0] = io_wdata;
    end
    if (io_we && io_adr == 3'd1) begin
      mtime_nxt[63:32] = io_wdata;
    end
  end

  // Timer, compare and software-interrupt registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime    <= 64'd0;
      mtimecmp <= '1;
      msip     <= 1'b0;
    end else begin
      mtime <= mtime_nxt;
      if (io_we) begin
        unique case (io_adr)
          3'd2:    mtimecmp[31:0]  <= io_wdata;
          3'd3:    mtimecmp[63:32] <= io_wdata;
          3'd4:    msip            <= io_wdata[0];
          default: ;
        endcase
      end
    end
  end

  // Two-flop synchroniser for the asynchronous external line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      meip  <= 1'b0;
    end else begin
      sync1 <= ext_irq_in;
      meip  <= sync1;
    end
  end

  assign mtip = (mtime >= mtimecmp);

  assign hit_mei = meip & csr_meie;
  assign hit_msi = msip & csr_msie;

  assign take = csr_mstatus_mie &
                (hit_mei | hit_msi | (mtip & csr_mtie));

  // Cause encoder: MEI over MSI over MTI
  always_comb begin
    code_nxt = 4'd7;
    priority case (1'b1)
      hit_mei: code_nxt = 4'd11;
      hit_msi: code_nxt = 4'd3;
      default: code_nxt = 4'd7;
    endcase
  end

  // Request FSM: one pulse per trap, re-armed by mret
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      g_interrupt      <= 1'b0;
      g_interrupt_code <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take && !stall) begin
            state            <= FIRE;
            g_interrupt      <= 1'b1;
            g_interrupt_code <= code_nxt;
          end
        end
        FIRE: begin
          state       <= WAIT_MRET;
          g_interrupt <= 1'b0;
        end
        WAIT_MRET: begin
          if (cmd_mret_ex) begin
            state <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          g_interrupt <= 1'b0;
        end
      endcase
    end
  end

  assign mip = {20'd0, meip, 3'd0, mtip,
                3'd0, msip, 3'd0};

  // Combinational register read mux
  always_comb begin
    io_rdata = 32'd0;
    unique case (io_adr)
      3'd0:    io_rdata = mtime[31:0];
      3'd1:    io_rdata = mtime[63:32];
      3'd2:    io_rdata = mtimecmp[31:0];
      3'd3:    io_rdata = mtimecmp[63:32];
      3'd4:    io_rdata = {31'd0, msip};
      3'd5:    io_rdata = mip;
      default: io_rdata = 32'd0;
    endcase
  end

endmodule
